// File: rtl/rs_stream_encoder_pkg.sv
// Shared types, constants and elaboration-time GF(2^8) helpers for the RS(255,239) encoder.
// Field is GF(2^8) over 0x11D; generator roots are @^B0 .. @^(B0+15).
package rs_stream_encoder_pkg;

    localparam int NB_SYMBOL_BITS      = 8;
    localparam int CORRECTION_CAPACITY = 8;
    localparam int BLOCK_LENGTH        = 255;
    localparam int PARITY_LENGTH       = 2 * CORRECTION_CAPACITY;
    localparam int MESSAGE_LENGTH      = BLOCK_LENGTH - PARITY_LENGTH;
    localparam int B0                  = 0;
    localparam logic [NB_SYMBOL_BITS-1:0] PRIM_POLY_LOW = 8'h1D;

    typedef logic [NB_SYMBOL_BITS-1:0] rs_sym_t;
    typedef logic [PARITY_LENGTH-1:0][NB_SYMBOL_BITS-1:0] rs_par_t;
    typedef enum logic {MSG, PARITY} rs_enc_state_e;

    function automatic rs_sym_t gf_mul_c(input rs_sym_t a, input rs_sym_t b);
        rs_sym_t p;
        rs_sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < NB_SYMBOL_BITS; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[NB_SYMBOL_BITS-2:0], 1'b0} ^ (x[NB_SYMBOL_BITS-1] ? PRIM_POLY_LOW : '0);
        end
        return p;
    endfunction

    // g(x) = prod (x + @^i); the monic x^16 term is implicit and not stored.
    function automatic rs_par_t gen_poly_c();
        rs_sym_t g [PARITY_LENGTH+1];
        rs_sym_t root;
        rs_par_t res;
        for (int j = 0; j <= PARITY_LENGTH; j++) g[j] = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < B0; i++) root = gf_mul_c(root, 8'h02);
        for (int i = 0; i < PARITY_LENGTH; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul_c(g[j], root);
            g[0] = gf_mul_c(g[0], root);
            root = gf_mul_c(root, 8'h02);
        end
        for (int j = 0; j < PARITY_LENGTH; j++) res[j] = g[j];
        return res;
    endfunction

    localparam rs_par_t GEN_POLY = gen_poly_c();

endpackage

// File: rtl/rs_stream_encoder_gf_const_mul.sv
// Combinational multiply of a symbol by a constant in GF(2^8); reduces to a fixed XOR network.
module rs_gf_const_mul
    import rs_stream_encoder_pkg::*;
#(
    parameter rs_sym_t COEF = 8'h01
) (
    input  rs_sym_t a_i,
    output rs_sym_t p_o
);

    // Each set input bit contributes the constant column COEF * x^i.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < NB_SYMBOL_BITS; i++) begin
            if (a_i[i]) p_o = p_o ^ gf_mul_c(rs_sym_t'(1) << i, COEF);
        end
    end

endmodule

// File: rtl/rs_stream_encoder.sv
// Systematic RS(255,239) stream encoder: 239 message symbols pass through, then 16 parity symbols.
// One output register (1 clk latency, no skid); input stalls while the register is held or parity drains.
module rs_stream_encoder
    import rs_stream_encoder_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NB_SYMBOL_BITS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NB_SYMBOL_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_parity
);

    localparam logic [7:0] LAST_MSG_POS = 8'(MESSAGE_LENGTH - 1);
    localparam logic [7:0] LAST_POS     = 8'(BLOCK_LENGTH - 1);

    rs_enc_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    rs_par_t       r_q, r_d;
    rs_sym_t       data_q, data_d;
    logic          vld_q, vld_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          par_q, par_d;

    rs_sym_t fb;
    rs_par_t fb_mul;
    logic    slot_free;

    assign fb        = in_data ^ r_q[PARITY_LENGTH-1];
    assign slot_free = !vld_q || out_ready;

    for (genvar gi = 0; gi < PARITY_LENGTH; gi++) begin : g_mul
        rs_gf_const_mul #(.COEF(GEN_POLY[gi])) u_mul (
            .a_i (fb),
            .p_o (fb_mul[gi])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        data_d   = data_q;
        vld_d    = vld_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        par_d    = par_q;
        in_ready = 1'b0;
        case (state_q)
            MSG: begin
                in_ready = slot_free && !rst;
                if (slot_free) begin
                    if (in_valid) begin
                        data_d = in_data;
                        vld_d  = 1'b1;
                        sop_d  = (cnt_q == 8'd0);
                        eop_d  = 1'b0;
                        par_d  = 1'b0;
                        r_d[0] = fb_mul[0];
                        for (int i = 1; i < PARITY_LENGTH; i++) r_d[i] = r_q[i-1] ^ fb_mul[i];
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == LAST_MSG_POS) state_d = PARITY;
                    end else begin
                        vld_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (slot_free) begin
                    data_d = r_q[PARITY_LENGTH-1];
                    vld_d  = 1'b1;
                    sop_d  = 1'b0;
                    par_d  = 1'b1;
                    eop_d  = (cnt_q == LAST_POS);
                    r_d    = {r_q[PARITY_LENGTH-2:0], rs_sym_t'(0)};
                    // The register has fully shifted out by the last parity symbol.
                    if (cnt_q == LAST_POS) begin
                        cnt_d   = 8'd0;
                        state_d = MSG;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = MSG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MSG;
            cnt_q   <= '0;
            r_q     <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            par_q   <= par_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = vld_q;
    assign out_sop    = sop_q;
    assign out_eop    = eop_q;
    assign out_parity = par_q;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder: table-based GF model, long-division parity, syndrome check per codeword.
module tb_rs_stream_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       out_parity;

    always #5 clk = ~clk;

    rs_stream_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_parity (out_parity)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       par;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         popped = 0;
    int         streak = 0;
    int         max_streak = 0;
    logic       rand_rdy = 1'b0;
    int         gf_exp [512];
    int         gf_log [256];
    int         g [17];
    int         syn [16];
    logic [7:0] msg [239];

    function automatic int mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[gf_log[a] + gf_log[b]];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic init_model();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gf_exp[i]       = x;
            gf_exp[i + 255] = x;
            gf_log[x]       = i;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11D;
        end
        gf_exp[510] = gf_exp[0];
        gf_exp[511] = gf_exp[1];
        gf_log[0] = 0;
        for (int j = 0; j < 17; j++) g[j] = 0;
        g[0] = 1;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ mul(g[j], gf_exp[i]);
            g[0] = mul(g[0], gf_exp[i]);
        end
        for (int i = 0; i < 16; i++) syn[i] = 0;
    endtask

    // Parity = remainder of m(x)*x^16 divided by g(x), by plain long division.
    task automatic queue_block();
        int   w [255];
        int   c;
        exp_t e;
        for (int p = 0; p < 239; p++) w[254 - p] = int'(msg[p]);
        for (int d = 0; d < 16; d++) w[d] = 0;
        for (int d = 254; d >= 16; d--) begin
            c = w[d];
            if (c != 0) for (int j = 0; j <= 16; j++) w[d - 16 + j] = w[d - 16 + j] ^ mul(c, g[j]);
        end
        for (int p = 0; p < 255; p++) begin
            e.d   = (p < 239) ? msg[p] : 8'(w[254 - p]);
            e.sop = (p == 0);
            e.eop = (p == 254);
            e.par = (p >= 239);
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] s, output int stalls);
        logic acc;
        logic done;
        in_valid = 1'b1;
        in_data  = s;
        stalls   = 0;
        done     = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
            else stalls++;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_msg(input int n, input logic gaps);
        int st;
        for (int p = 0; p < n; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom_range(0, 255));
                    @(posedge clk);
                    #1;
                end
            end
            send(msg[p], st);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_queue_empty", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        sb_q.delete();
        rst = 1'b0;
    endtask

    // Monitor: pops on every output handshake and accumulates syndromes S_i = c(@^i).
    initial begin
        exp_t e;
        int   bad;
        forever begin
            @(negedge clk);
            if (rst) begin
                streak = 0;
                popped = 0;
                for (int i = 0; i < 16; i++) syn[i] = 0;
            end else begin
                if (out_valid) streak++;
                else streak = 0;
                if (streak > max_streak) max_streak = streak;
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output: got data %0h with empty scoreboard", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        if ({out_data, out_sop, out_eop, out_parity} !== e) begin
                            n_err++;
                            $display("FAIL out_sym pos %0d: got d=%0h sop=%0b eop=%0b par=%0b expected d=%0h sop=%0b eop=%0b par=%0b",
                                     popped, out_data, out_sop, out_eop, out_parity, e.d, e.sop, e.eop, e.par);
                        end
                    end
                    for (int i = 0; i < 16; i++) syn[i] = mul(syn[i], gf_exp[i]) ^ int'(out_data);
                    popped++;
                    if (out_eop) begin
                        bad = 0;
                        for (int i = 0; i < 16; i++) if (syn[i] != 0) bad++;
                        check("codeword_syndromes_nonzero", bad, 0);
                        for (int i = 0; i < 16; i++) syn[i] = 0;
                        popped = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int st;
        int k;
        init_model();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;

        // Reset state, with in_valid held high to prove it is ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sop", int'(out_sop), 0);
        check("rst_out_eop", int'(out_eop), 0);
        check("rst_out_parity", int'(out_parity), 0);
        check("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;

        // All-zero message.
        for (int p = 0; p < 239; p++) msg[p] = 8'h00;
        queue_block();
        send_msg(239, 1'b0);
        drain();

        // Impulse at x^16: parity equals the generator's low coefficients.
        msg[238] = 8'h01;
        queue_block();
        send_msg(239, 1'b0);
        drain();

        // Random messages with input gaps and output backpressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 12; b++) begin
            for (int p = 0; p < 239; p++) msg[p] = 8'($urandom_range(0, 255));
            if (b == 0) for (int p = 0; p < 239; p++) msg[p] = 8'hFF;
            queue_block();
            send_msg(239, 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during the message phase, then during the parity phase.
        for (int p = 0; p < 239; p++) msg[p] = 8'($urandom_range(0, 255));
        queue_block();
        send_msg(100, 1'b0);
        do_reset(2);
        queue_block();
        send_msg(239, 1'b0);
        k = 0;
        while (popped < 245 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reach_pos_245", int'(popped >= 245), 1);
        do_reset(2);
        for (int p = 0; p < 239; p++) msg[p] = 8'($urandom_range(0, 255));
        queue_block();
        send_msg(239, 1'b0);
        drain();

        // Back-to-back blocks at full rate.
        max_streak = 0;
        for (int p = 0; p < 239; p++) msg[p] = 8'($urandom_range(0, 255));
        queue_block();
        send(msg[0], st);
        check("b2b_first_stalls", st, 0);
        for (int p = 1; p < 239; p++) send(msg[p], st);
        for (int p = 0; p < 239; p++) msg[p] = 8'($urandom_range(0, 255));
        queue_block();
        send(msg[0], st);
        check("b2b_parity_stall_cycles", st, 16);
        for (int p = 1; p < 239; p++) send(msg[p], st);
        in_valid = 1'b0;
        drain();
        check("b2b_valid_streak", max_streak, 510);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
